// File: rtl/mult_pkg.sv
// Shared constants for the multiplier family.
//   MULT4_W : operand width of the nibble multiplier
//   PROD_W  : full unsigned product width (2*MULT4_W)
package mult_pkg;
  localparam int MULT4_W = 4;
  localparam int PROD_W  = 2 * MULT4_W;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/mult4_seq_if.sv
// Operand/result bundle for mult4_seq.
//   a, b      : unsigned operands (W bits)
//   in_valid  : operands valid this cycle
//   product   : registered a*b (2*W bits)
//   out_valid : product holds a new result this cycle
// master drives operands, slave (the multiplier) drives results.
interface mult4_seq_if
  import mult_pkg::*;
#(
  parameter int W = MULT4_W
);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           in_valid;
  logic [2*W-1:0] product;
  logic           out_valid;

  modport master (output a, b, in_valid, input  product, out_valid);
  modport slave  (input  a, b, in_valid, output product, out_valid);
endinterface

// File: rtl/mult_full_adder.sv
// One-bit full adder cell of the array multiplier.
//   a, b, cin -> sum, cout
module mult_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mult4_seq.sv
// Unsigned W x W array multiplier with a single output register.
//   clk, rst_n : rising-edge clock, async active-low reset
//   bus        : slave side of mult4_seq_if (a, b, in_valid in;
//                product, out_valid out), latency exactly one cycle
// AND partial products feed (W-1) ripple-carry rows of full adders;
// each row retires its LSB as one product bit and passes the rest
// (plus its carry) down to the next row.
module mult4_seq
  import mult_pkg::*;
#(
  parameter int W = MULT4_W
) (
  input  logic         clk,
  input  logic         rst_n,
  mult4_seq_if.slave   bus
);
  logic [W-1:0][W-1:0] pp;    // pp[i][j] = a[j] & b[i]
  logic [W-1:0][W-1:0] s;     // running sum after row i
  logic [W-1:0]        rc;    // carry out of row i
  logic [2*W-1:0]      prod_c;
  logic [2*W-1:0]      prod_q;
  logic                vld_q;

  for (genvar i = 0; i < W; i++) begin : g_pp
    assign pp[i] = bus.a & {W{bus.b[i]}};
  end

  // Row 0 is the first partial product unchanged, no carry.
  assign s[0]  = pp[0];
  assign rc[0] = 1'b0;

  for (genvar i = 1; i < W; i++) begin : g_row
    logic [W:0]   cy;
    logic [W-1:0] y;
    assign cy[0] = 1'b0;
    // Previous row shifted right by one; its carry becomes the new MSB.
    assign y     = {rc[i-1], s[i-1][W-1:1]};
    for (genvar j = 0; j < W; j++) begin : g_fa
      mult_full_adder u_fa (
        .a    (pp[i][j]),
        .b    (y[j]),
        .cin  (cy[j]),
        .sum  (s[i][j]),
        .cout (cy[j+1])
      );
    end
    assign rc[i] = cy[W];
  end

  // Low bits retire one per row; the last row supplies the top W+1 bits.
  for (genvar i = 0; i < W-1; i++) begin : g_lo
    assign prod_c[i] = s[i][0];
  end
  assign prod_c[2*W-2:W-1] = s[W-1];
  assign prod_c[2*W-1]     = rc[W-1];

  // product only updates on a valid edge so the last result stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) prod_q <= prod_c;
    end
  end

  assign bus.product   = prod_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_mult4_seq.sv
// Directed bench for mult4_seq: reset behaviour, hand-computed vectors,
// streaming, async mid-stream reset and an exhaustive back-to-back sweep.
module tb_mult4_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  mult4_seq_if #(.W(4)) bus ();

  mult4_seq #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply operands, take one edge, sample 1 time unit later.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v);
    bus.a = a; bus.b = b; bus.in_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] p, input logic v);
    check({tag, ".product"}, bus.product, p);
    check({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, v});
  endtask

  initial begin
    bus.a = 4'd5; bus.b = 4'd3; bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_hold", 8'd0, 1'b0);

    #3 rst_n = 1'b1;
    step(4'd3, 4'd5, 1'b1);   expect_out("basic_3x5", 8'd15, 1'b1);
    step(4'd3, 4'd5, 1'b0);   expect_out("basic_idle", 8'd15, 1'b0);

    step(4'd7, 4'd7, 1'b1);   expect_out("7x7", 8'd49, 1'b1);
    step(4'd7, 4'd0, 1'b1);   expect_out("7x0", 8'd0, 1'b1);
    step(4'd1, 4'd6, 1'b1);   expect_out("1x6", 8'd6, 1'b1);
    step(4'd15, 4'd15, 1'b1); expect_out("15x15", 8'd225, 1'b1);
    step(4'd8, 4'd2, 1'b1);   expect_out("8x2", 8'd16, 1'b1);
    step(4'd15, 4'd1, 1'b1);  expect_out("15x1", 8'd15, 1'b1);
    step(4'd0, 4'd15, 1'b1);  expect_out("0x15", 8'd0, 1'b1);

    step(4'd2, 4'd3, 1'b1);   expect_out("stream0", 8'd6, 1'b1);
    step(4'd4, 4'd4, 1'b1);   expect_out("stream1", 8'd16, 1'b1);
    step(4'd9, 4'd11, 1'b1);  expect_out("stream2", 8'd99, 1'b1);
    step(4'd1, 4'd1, 1'b0);   expect_out("stream_end", 8'd99, 1'b0);

    // Async reset in mid-cycle right after a valid result.
    step(4'd15, 4'd15, 1'b1); expect_out("pre_reset", 8'd225, 1'b1);
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 8'd0, 1'b0);
    // Edge with in_valid=1 while still in reset is ignored.
    @(posedge clk); #1;
    expect_out("reset_edge", 8'd0, 1'b0);
    #3 rst_n = 1'b1;

    // Exhaustive sweep, one pair per cycle.
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ea, eb;
      ea = 4'(i >> 4);
      eb = 4'(i);
      step(ea, eb, 1'b1);
      expect_out($sformatf("sweep_%0dx%0d", ea, eb), 8'(ea * eb), 1'b1);
    end
    step(4'd0, 4'd0, 1'b0);
    expect_out("sweep_end", 8'd225, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mult4_seq.md
Name: mult4_seq

Overview:
- Unsigned 4-bit x 4-bit multiplier producing an 8-bit product, registered on one clock edge.
- Building block of the 8-bit sign-magnitude multiplier:
  - four instances compute nibble partial products (3-bit magnitudes zero-extended to 4 bits);
  - the parent shifts and sums them.
- Array-multiplier datapath (AND partial products + full-adder rows) followed by an output register with a valid flag.

Parameters:
- W, 4, operand width in bits; the product is 2*W bits. Only W=4 is required to be verified; RTL stays generic.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  W  multiplicand, unsigned
- b  input  W  multiplier, unsigned
- in_valid  input  1  a/b valid this cycle
- product  output  2*W  registered unsigned product a*b
- out_valid  output  1  product holds a new result this cycle

Behaviour:
- Reset:
  - rst_n low asynchronously clears product to 0 and out_valid to 0, independent of clk.
  - Outputs hold 0 until the first qualifying edge after rst_n rises.
- Arithmetic:
  - product = a * b, full 2*W-bit unsigned result. No truncation or overflow is possible: max 15*15=225 fits in 8 bits.
  - Operands with MSB 0 (the parent's usage) give at most 7*7=49.
- Datapath:
  - Partial products pp[i][j] = a[j] & b[i].
  - Row 0 is passed through. Rows 1..W-1 are summed with ripple-carry full-adder rows, each row shifted by i.
  - The final carry feeds product[2W-1].
  - Purely combinational up to the output register; no internal state besides the output register.
- Timing:
  - Latency is exactly 1 cycle. On a rising clk edge with in_valid=1, product <= a*b and out_valid <= 1.
  - On an edge with in_valid=0:
    - out_valid <= 0;
    - product holds its previous value and is not cleared.
  - Back-to-back in_valid every cycle is allowed: throughput 1 result/cycle, no stall, no backpressure.
- Boundaries:
  - Either operand 0 gives product 0.
  - All-ones operands give 225.
  - Reset asserted mid-stream discards the in-flight result: out_valid=0 and product=0 immediately.
  - Reset released on the same edge as in_valid=1: the edge is ignored if rst_n is still low at the edge.
- X-safety: no latches; every register has a reset value.

Decomposition:
- Shared package mult_pkg:
  - localparam MULT4_W = 4;
  - product width function/constant PROD_W = 2*MULT4_W.
- Natural sub-module: mult_full_adder (a, b, cin -> sum, cout). It is instantiated in a generate loop forming the (W-1) x W adder array.
- The parent mult remains responsible for sign handling (XOR of operand MSBs) and the shifted sum of four mult4_seq results. Its shift alignment accounts for the one-cycle mult4_seq latency.

Test Plan:
- Reset: hold rst_n=0 with a=5, b=3, in_valid=1, clk toggling -> product=0, out_valid=0. Assert rst_n low mid-cycle after a valid result -> both clear without waiting for an edge.
- Basic: a=3, b=5, in_valid=1 -> next edge product=15 (0x0F), out_valid=1. Following edge with in_valid=0 -> out_valid=0, product stays 15.
- Parent range: a=7, b=7 -> 49 (0x31); a=7, b=0 -> 0; a=1, b=6 -> 6.
- Full range: a=15, b=15 -> 225 (0xE1); a=8, b=2 -> 16; a=15, b=1 -> 15.
- Streaming: in_valid=1 for consecutive cycles with (2,3), (4,4), (9,11) -> products 6, 16, 99 on successive edges. out_valid stays high for all three cycles, then drops.
- Exhaustive: all 256 a/b pairs streamed back-to-back -> each product equals a*b one cycle later; checked against a reference model.
